// File: rtl/zinde_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | zinde_pkg: opcode map and control-FSM encoding for the Zinde core  |
// | Revision: 2.0                                                      |
// +--------------------------------------------------------------------+
package zinde_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_STA  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JC   = 4'hA;
  localparam logic [3:0] OP_INC  = 4'hB;
  localparam logic [3:0] OP_NOT  = 4'hC;
  localparam logic [3:0] OP_CLR  = 4'hD;
  localparam logic [3:0] OP_NOP2 = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_ADDR   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

endpackage : zinde_pkg
`default_nettype wire

// File: rtl/zinde_cpu_core_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | zinde_cpu_core_if: req/ready memory bus between core and memory    |
// | Revision: 2.0                                                      |
// +--------------------------------------------------------------------+
interface zinde_cpu_core_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );

endinterface : zinde_cpu_core_if
`default_nettype wire

// File: rtl/zinde_alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | zinde_alu: combinational accumulator ALU (result, carry, zero)     |
// | Revision: 2.0                                                      |
// +--------------------------------------------------------------------+
module zinde_alu
  import zinde_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] ac,
  input  logic [DATA_W-1:0] operand,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_one;

  assign w_one = {{DATA_W{1'b0}}, 1'b1};

  always_comb begin
    w_sum  = '0;
    result = ac;
    carry  = 1'b0;
    case (op)
      OP_LDA: result = operand;
      OP_ADD: begin
        w_sum  = {1'b0, ac} + {1'b0, operand};
        result = w_sum[DATA_W-1:0];
        carry  = w_sum[DATA_W];
      end
      // Two's-complement subtract: carry out set means no borrow (AC >= M).
      OP_SUB: begin
        w_sum  = {1'b0, ac} + {1'b0, ~operand} + w_one;
        result = w_sum[DATA_W-1:0];
        carry  = w_sum[DATA_W];
      end
      OP_AND: result = ac & operand;
      OP_OR:  result = ac | operand;
      OP_XOR: result = ac ^ operand;
      OP_INC: begin
        w_sum  = {1'b0, ac} + w_one;
        result = w_sum[DATA_W-1:0];
        carry  = w_sum[DATA_W];
      end
      OP_NOT: result = ~ac;
      OP_CLR: result = '0;
      default: result = ac;
    endcase
  end

  assign zero = (result == '0);

endmodule : zinde_alu
`default_nettype wire

// File: rtl/zinde_cpu_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | zinde_cpu_core: parametrised accumulator CPU, control FSM+datapath |
// | Revision: 2.0                                                      |
// +--------------------------------------------------------------------+
module zinde_cpu_core
  import zinde_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  zinde_cpu_core_if.master  mem,
  output logic              halted,
  output logic [ADDR_W-1:0] test_pc,
  output logic [ADDR_W-1:0] test_ar,
  output logic [DATA_W-1:0] test_ac,
  output logic [DATA_W-1:0] test_ir,
  output logic [1:0]        test_flags
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_ar;
  logic [DATA_W-1:0] r_ac;
  logic [DATA_W-1:0] r_ir;
  logic              r_c;
  logic              r_z;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic              r_halted;

  logic [3:0]        w_op;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_is_branch;
  logic              w_taken;
  logic              w_carry_op;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry;
  logic              w_alu_zero;

  assign w_op        = r_ir[3:0];
  assign w_rd_addr   = mem.mem_rdata[ADDR_W-1:0];
  assign w_next_pc   = r_pc + ADDR_W'(1);
  assign w_is_branch = (w_op == OP_JMP) || (w_op == OP_JZ) || (w_op == OP_JC);
  assign w_taken     = (w_op == OP_JMP) || ((w_op == OP_JZ) && r_z) ||
                       ((w_op == OP_JC) && r_c);
  assign w_carry_op  = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_INC);

  zinde_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .ac      (r_ac),
    .operand (mem.mem_rdata),
    .op      (w_op),
    .result  (w_alu_result),
    .carry   (w_alu_carry),
    .zero    (w_alu_zero)
  );

  // Bus outputs are registered and only change at a completing edge, so
  // they stay stable across wait states without extra holding logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_START;
      r_pc     <= ADDR_W'(RESET_PC);
      r_ar     <= '0;
      r_ac     <= '0;
      r_ir     <= '0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_START: begin
          r_state <= ST_FETCH;
          r_req   <= 1'b1;
          r_we    <= 1'b0;
          r_addr  <= r_pc;
        end

        ST_FETCH: begin
          if (mem.mem_ready) begin
            r_ir    <= mem.mem_rdata;
            r_pc    <= w_next_pc;
            r_req   <= 1'b0;
            r_state <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          case (w_op)
            OP_NOP, OP_NOP2: begin
              r_state <= ST_FETCH;
              r_req   <= 1'b1;
              r_addr  <= r_pc;
            end
            OP_INC, OP_NOT, OP_CLR: begin
              r_ac    <= w_alu_result;
              r_z     <= w_alu_zero;
              if (w_carry_op) r_c <= w_alu_carry;
              r_state <= ST_FETCH;
              r_req   <= 1'b1;
              r_addr  <= r_pc;
            end
            OP_HLT: begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end
            default: begin
              r_state <= ST_ADDR;
              r_req   <= 1'b1;
              r_we    <= 1'b0;
              r_addr  <= r_pc;
            end
          endcase
        end

        ST_ADDR: begin
          if (mem.mem_ready) begin
            r_ar <= w_rd_addr;
            if (w_is_branch) begin
              r_pc    <= w_taken ? w_rd_addr : w_next_pc;
              r_addr  <= w_taken ? w_rd_addr : w_next_pc;
              r_state <= ST_FETCH;
            end else begin
              r_pc    <= w_next_pc;
              r_addr  <= w_rd_addr;
              r_we    <= (w_op == OP_STA);
              r_state <= ST_MEM;
            end
          end
        end

        ST_MEM: begin
          if (mem.mem_ready) begin
            if (w_op != OP_STA) begin
              r_ac <= w_alu_result;
              r_z  <= w_alu_zero;
              if (w_carry_op) r_c <= w_alu_carry;
            end
            r_we    <= 1'b0;
            r_addr  <= r_pc;
            r_state <= ST_FETCH;
          end
        end

        ST_HALT: begin
          r_req    <= 1'b0;
          r_halted <= 1'b1;
        end

        default: begin
          r_state <= ST_START;
          r_req   <= 1'b0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_ac;

  assign halted     = r_halted;
  assign test_pc    = r_pc;
  assign test_ar    = r_ar;
  assign test_ac    = r_ac;
  assign test_ir    = r_ir;
  assign test_flags = {r_c, r_z};

endmodule : zinde_cpu_core
`default_nettype wire

// File: tb/tb_zinde_cpu_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_zinde_cpu_core: vector table, directed sequences, random progs  |
// | Revision: 2.0                                                      |
// +--------------------------------------------------------------------+
module tb_zinde_cpu_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  zinde_cpu_core_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  logic       halted;
  logic [7:0] test_pc, test_ar, test_ac, test_ir;
  logic [1:0] test_flags;

  zinde_cpu_core #(.DATA_W(8), .ADDR_W(8), .RESET_PC(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem        (bus),
    .halted     (halted),
    .test_pc    (test_pc),
    .test_ar    (test_ar),
    .test_ac    (test_ac),
    .test_ir    (test_ir),
    .test_flags (test_flags)
  );

  logic [7:0] mem [256];
  logic [3:0] wait_cnt = '0;
  int         cur_wait = 0;
  int         cfg_wait = 0;
  bit         cfg_rand = 1'b0;
  int         wait_total = 0;
  int         dut_writes[$];
  int         checks = 0;
  int         failures = 0;

  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.mem_ready = (int'(wait_cnt) >= cur_wait);

  // Reference model state: architectural interpreter over its own memory copy
  typedef struct {
    int ac; int c; int z; int pc; int ir; int ar; int cyc; bit halted;
  } res_t;
  int mm [256];
  int exp_writes[$];

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_ac;
    logic       exp_c;
    logic       exp_z;
  } vec_t;
  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic start_prog(input int w, input bit r);
    rst = 1'b0;
    cfg_wait = w;
    cfg_rand = r;
    @(negedge clk);
    @(negedge clk);
    wait_total = 0;
    dut_writes.delete();
    clear_mem();
  endtask

  task automatic run_to_halt(output int cyc);
    rst = 1'b1;
    cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cyc++;
      if (halted === 1'b1) break;
    end
    chk("halted", {31'd0, halted}, 32'd1);
  endtask

  task automatic quiet_check();
    int n;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.mem_req !== 1'b0) n++;
    end
    chk("no_req_after_halt", n, 0);
  endtask

  task automatic model_run(output res_t r);
    int pc, ac, c, z, ir, ar, cyc, steps, op, a, s;
    bit h;
    pc = 0; ac = 0; c = 0; z = 0; ir = 0; ar = 0; cyc = 1; steps = 0; h = 1'b0;
    exp_writes.delete();
    while (!h && steps < 400) begin
      steps++;
      ir = mm[pc]; pc = (pc + 1) % 256; cyc += 2; op = ir % 16;
      if (op >= 1 && op <= 10) begin
        a = mm[pc]; pc = (pc + 1) % 256; ar = a; cyc += 1;
        if (op == 8 || (op == 9 && z == 1) || (op == 10 && c == 1)) pc = a;
        else if (op <= 7) begin
          cyc += 1;
          case (op)
            1: ac = mm[a];
            2: begin mm[a] = ac; exp_writes.push_back(a * 256 + ac); end
            3: begin s = ac + mm[a]; c = (s > 255) ? 1 : 0; ac = s % 256; end
            4: begin c = (ac >= mm[a]) ? 1 : 0; ac = (ac - mm[a] + 256) % 256; end
            5: ac = ac & mm[a];
            6: ac = ac | mm[a];
            default: ac = ac ^ mm[a];
          endcase
          if (op != 2) z = (ac == 0) ? 1 : 0;
        end
      end else begin
        case (op)
          11: begin s = ac + 1; c = (s > 255) ? 1 : 0; ac = s % 256; z = (ac == 0) ? 1 : 0; end
          12: begin ac = 255 - ac; z = (ac == 0) ? 1 : 0; end
          13: begin ac = 0; z = 1; end
          15: h = 1'b1;
          default: ;
        endcase
      end
    end
    r.ac = ac; r.c = c; r.z = z; r.pc = pc; r.ir = ir; r.ar = ar; r.cyc = cyc; r.halted = h;
  endtask

  // Random code in 0x00..0x4F, forward-only branches, data in 0x80..0xFF
  task automatic gen_prog();
    int pos, op;
    for (int i = 128; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    pos = 0;
    while (pos < 8'h50) begin
      op = $urandom_range(0, 14);
      mem[pos] = {4'($urandom_range(0, 15)), 4'(op)};
      pos++;
      if (op >= 1 && op <= 10) begin
        if (op >= 8) mem[pos] = 8'(pos + 1 + $urandom_range(0, 6));
        else mem[pos] = 8'(128 + $urandom_range(0, 127));
        pos++;
      end
    end
    for (int i = pos; i < 128; i++) mem[i] = {4'($urandom_range(0, 15)), 4'hF};
  endtask

  initial begin
    int cyc;
    res_t r;
    bit ok;

    vecs[0]  = '{4'h3, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
    vecs[1]  = '{4'h3, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0};
    vecs[2]  = '{4'h4, 8'h55, 8'h55, 8'h00, 1'b1, 1'b1};
    vecs[3]  = '{4'h4, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
    vecs[4]  = '{4'h5, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b1};
    vecs[5]  = '{4'h6, 8'hA0, 8'h05, 8'hA5, 1'b1, 1'b0};
    vecs[6]  = '{4'h7, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1};
    vecs[7]  = '{4'h1, 8'h00, 8'h7E, 8'h7E, 1'b1, 1'b0};
    vecs[8]  = '{4'hB, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{4'hB, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b0};
    vecs[10] = '{4'hC, 8'h0F, 8'h00, 8'hF0, 1'b1, 1'b0};
    vecs[11] = '{4'hD, 8'h5A, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[12] = '{4'hC, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[13] = '{4'h0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};

    // Memory responder and wait-state stability monitor
    fork
      forever begin
        @(posedge clk);
        if (!rst) begin
          wait_cnt <= '0;
          cur_wait <= cfg_wait;
        end else if (!bus.mem_req) begin
          wait_cnt <= '0;
          if (!cfg_rand) cur_wait <= cfg_wait;
        end else if (bus.mem_ready) begin
          if (bus.mem_we) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            dut_writes.push_back(int'({bus.mem_addr, bus.mem_wdata}));
          end
          wait_cnt <= '0;
          cur_wait <= cfg_rand ? int'($urandom_range(0, 3)) : cfg_wait;
        end else begin
          wait_cnt <= wait_cnt + 4'd1;
          wait_total = wait_total + 1;
        end
      end
      begin
        bit         prev_wait;
        logic [7:0] p_addr, p_wdata;
        logic       p_we;
        prev_wait = 1'b0;
        forever begin
          @(negedge clk);
          if (prev_wait && rst) begin
            chk("stable_addr", {24'd0, bus.mem_addr}, {24'd0, p_addr});
            chk("stable_we", {31'd0, bus.mem_we}, {31'd0, p_we});
            chk("stable_wdata", {24'd0, bus.mem_wdata}, {24'd0, p_wdata});
          end
          prev_wait = rst && bus.mem_req && !bus.mem_ready;
          p_addr = bus.mem_addr; p_we = bus.mem_we; p_wdata = bus.mem_wdata;
        end
      end
    join_none

    // Reset values while held, then first request one edge after release
    start_prog(0, 1'b0);
    mem[0] = 8'h0F;
    @(negedge clk);
    chk("rst_req", {31'd0, bus.mem_req}, 0);
    chk("rst_we", {31'd0, bus.mem_we}, 0);
    chk("rst_addr", {24'd0, bus.mem_addr}, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    chk("rst_pc", {24'd0, test_pc}, 0);
    chk("rst_ac", {24'd0, test_ac}, 0);
    chk("rst_ir", {24'd0, test_ir}, 0);
    chk("rst_ar", {24'd0, test_ar}, 0);
    chk("rst_flags", {30'd0, test_flags}, 0);
    rst = 1'b1;
    #1 chk("start_no_req", {31'd0, bus.mem_req}, 0);
    @(negedge clk);
    chk("first_req", {31'd0, bus.mem_req}, 1);
    chk("first_addr", {24'd0, bus.mem_addr}, 0);
    chk("first_we", {31'd0, bus.mem_we}, 0);

    // Reference program, zero wait then three waits per access
    for (int w = 0; w <= 3; w += 3) begin
      start_prog(w, 1'b0);
      {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6]} =
        {8'h01, 8'h10, 8'h03, 8'h11, 8'h02, 8'h12, 8'h0F};
      mem[8'h10] = 8'hF0;
      mem[8'h11] = 8'h20;
      run_to_halt(cyc);
      chk("prog_cycles", cyc, (w == 0) ? 15 : 45);
      chk("prog_waits", wait_total, w * 10);
      chk("prog_nwrites", dut_writes.size(), 1);
      if (dut_writes.size() > 0) chk("prog_write", dut_writes[0], 32'h1210);
      chk("prog_flags", {30'd0, test_flags}, 32'd2);
      chk("prog_ac", {24'd0, test_ac}, 32'h10);
      chk("prog_pc", {24'd0, test_pc}, 32'h07);
      quiet_check();
    end

    // Table of single-operation vectors; C is 1 on entry (INC of 0xFF)
    foreach (vecs[k]) begin
      start_prog(0, 1'b0);
      {mem[0], mem[1], mem[2], mem[3], mem[4]} = {8'h01, 8'h82, 8'h0B, 8'h01, 8'h80};
      mem[5] = {4'h0, vecs[k].op};
      if (vecs[k].op inside {4'h0, 4'hB, 4'hC, 4'hD, 4'hE}) mem[6] = 8'h0F;
      else begin mem[6] = 8'h81; mem[7] = 8'h0F; end
      mem[8'h80] = vecs[k].a;
      mem[8'h81] = vecs[k].b;
      mem[8'h82] = 8'hFF;
      run_to_halt(cyc);
      chk($sformatf("vec%0d_ac", k), {24'd0, test_ac}, {24'd0, vecs[k].exp_ac});
      chk($sformatf("vec%0d_flags", k), {30'd0, test_flags}, {30'd0, vecs[k].exp_c, vecs[k].exp_z});
    end

    // CLR then JZ taken to 0x20
    start_prog(0, 1'b0);
    {mem[0], mem[1], mem[2]} = {8'h0D, 8'h09, 8'h20};
    mem[8'h20] = 8'h0F;
    run_to_halt(cyc);
    chk("jz_taken_pc", {24'd0, test_pc}, 32'h21);
    chk("jz_taken_ar", {24'd0, test_ar}, 32'h20);
    chk("jz_taken_cycles", cyc, 8);

    // INC then JZ not taken, falls through to 0x03
    start_prog(0, 1'b0);
    {mem[0], mem[1], mem[2], mem[3]} = {8'h0B, 8'h09, 8'h20, 8'h0F};
    mem[8'h20] = 8'h0B;
    run_to_halt(cyc);
    chk("jz_fall_pc", {24'd0, test_pc}, 32'h04);
    chk("jz_fall_ac", {24'd0, test_ac}, 32'h01);
    chk("jz_fall_flags", {30'd0, test_flags}, 0);

    // NOP at 0xFF wraps PC to 0x00, where an earlier STA placed HLT
    start_prog(0, 1'b0);
    {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]} = {8'h01, 8'h80, 8'h02, 8'h00, 8'h08, 8'hFF};
    mem[8'hFF] = 8'h00;
    mem[8'h80] = 8'h0F;
    run_to_halt(cyc);
    chk("wrap_pc", {24'd0, test_pc}, 32'h01);
    chk("wrap_cycles", cyc, 16);

    // Reset asserted during the STA data-phase wait
    start_prog(5, 1'b0);
    {mem[0], mem[1], mem[2], mem[3], mem[4]} = {8'h01, 8'h80, 8'h02, 8'h90, 8'h0F};
    mem[8'h80] = 8'h77;
    rst = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_we) begin ok = 1'b1; break; end
    end
    chk("sta_reached", {31'd0, ok}, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_req", {31'd0, bus.mem_req}, 0);
    chk("abort_we", {31'd0, bus.mem_we}, 0);
    chk("abort_nowrite", {24'd0, mem[8'h90]}, 0);
    chk("abort_nwrites", dut_writes.size(), 0);
    cfg_wait = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("restart_req", {31'd0, bus.mem_req}, 1);
    chk("restart_addr", {24'd0, bus.mem_addr}, 0);
    run_to_halt(cyc);
    chk("restart_write", {24'd0, mem[8'h90]}, 32'h77);
    chk("restart_pc", {24'd0, test_pc}, 32'h05);

    // Random programs with random wait states against the interpreter
    for (int t = 0; t < 8; t++) begin
      start_prog(0, 1'b1);
      r.halted = 1'b0;
      for (int tries = 0; tries < 20 && !r.halted; tries++) begin
        gen_prog();
        for (int i = 0; i < 256; i++) mm[i] = int'(mem[i]);
        model_run(r);
      end
      run_to_halt(cyc);
      chk($sformatf("rnd%0d_ac", t), {24'd0, test_ac}, r.ac);
      chk($sformatf("rnd%0d_flags", t), {30'd0, test_flags}, r.c * 2 + r.z);
      chk($sformatf("rnd%0d_pc", t), {24'd0, test_pc}, r.pc);
      chk($sformatf("rnd%0d_ir", t), {24'd0, test_ir}, r.ir);
      chk($sformatf("rnd%0d_ar", t), {24'd0, test_ar}, r.ar);
      chk($sformatf("rnd%0d_cycles", t), cyc, r.cyc + wait_total);
      chk($sformatf("rnd%0d_nwrites", t), dut_writes.size(), exp_writes.size());
      for (int i = 0; i < dut_writes.size() && i < exp_writes.size(); i++)
        chk($sformatf("rnd%0d_write%0d", t, i), dut_writes[i], exp_writes[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_zinde_cpu_core
`default_nettype wire

// File: doc/zinde_cpu_core.md
# zinde_cpu_core

Parametrised accumulator CPU core; successor of the fixed 8-bit Zinde CPU top. Internal control FSM plus datapath (PC, AR, IR, AC, Z/C flags), with configurable data/address widths, a req/ready memory handshake that tolerates wait states, conditional branches, flags and a halt state. Sits between the testbench/system memory model and nothing else; all architectural registers are exported for test.

## Interface
- DATA_W, 8: data and instruction word width; must be ≥ ADDR_W and ≥ 4.
- ADDR_W, 8: memory address width; PC and AR are ADDR_W bits.
- RESET_PC, 0: PC value after reset.

- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- mem_rdata  in  DATA_W  read data, valid in a cycle with mem_req=1, mem_we=0, mem_ready=1.
- mem_ready  in  1  completes the current access; ignored while mem_req=0.
- mem_req  out  1  access request.
- mem_we  out  1  1 = write, 0 = read; meaningful only with mem_req=1.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  write data (= AC).
- halted  out  1  core is in HALT.
- test_pc, test_ar  out  ADDR_W  PC, AR.
- test_ac, test_ir  out  DATA_W  AC, IR.
- test_flags  out  2  {C, Z}.

## Operation
- Opcode = IR[3:0]; upper IR bits ignored. Memory-reference instructions are two words: opcode word, then address word (low ADDR_W bits used).
- 0 NOP; 1 LDA a: AC←M[a]; 2 STA a: M[a]←AC; 3 ADD a: AC←AC+M[a]; 4 SUB a: AC←AC−M[a]; 5 AND; 6 OR; 7 XOR (with M[a]); 8 JMP a; 9 JZ a (jump if Z); A JC a (jump if C); B INC: AC←AC+1; C NOT; D CLR; E NOP; F HLT.
- Arithmetic modulo 2^DATA_W. ADD/INC: C = carry out. SUB: computed as AC+~M+1, C = carry out (1 ⇔ AC ≥ M unsigned). Other instructions leave C unchanged.
- Z = (new AC == 0), updated on every AC write (LDA, ADD..XOR, INC, NOT, CLR); unchanged otherwise.
- PC increments modulo 2^ADDR_W after every opcode/address fetch; 0xFF→0x00 for ADDR_W=8.
- FSM states: START, FETCH, DECODE, ADDR, MEM, HALT.
  - START: mem_req=0; → FETCH.
  - FETCH: read at PC; on ready IR←rdata, PC+1, → DECODE.
  - DECODE: NOP/E/INC/NOT/CLR execute here, → FETCH; HLT → HALT; opcodes 1–A → ADDR.
  - ADDR: read at PC; on ready PC+1 and AR←rdata; JMP, or JZ/JC with condition true: PC←rdata instead; branches → FETCH, 1–7 → MEM.
  - MEM: read (1,3–7) or write (2) at AR; on ready execute, → FETCH.
  - HALT: mem_req=0, halted=1; exit only by reset.
- mem_req=1 exactly in FETCH, ADDR, MEM; mem_addr/mem_we/mem_wdata held stable until mem_ready.

## Timing
- Reset (async, immediate): state START, PC=RESET_PC, AC=IR=AR=0, flags=0, mem_req=0, mem_we=0, mem_addr=0 outputs not driven by state, halted=0. mem_req drops in the same cycle reset asserts, even mid-access; access abandoned.
- First request: second rising edge after rst deasserts… precisely, START occupies the first cycle after release, FETCH the next.
- Zero-wait cycle counts: 1-word instructions 2 cycles; JMP/JZ/JC 3; LDA/STA/ALU 4. Each wait cycle (mem_ready=0 while mem_req=1) adds one cycle to that access.
- Register/flag updates take effect at the completing edge; visible on test outputs the next cycle.

## Structure
- Package zinde_pkg: opcode localparams (OP_NOP…OP_HLT), FSM state encoding.
- Sub-module zinde_alu (param DATA_W): combinational; inputs AC, operand, op; outputs result, carry, zero. Everything else (FSM, registers) in zinde_cpu_core.

## Test plan
- Reset: hold rst=0 with mem_ready=1 → all outputs at reset values, mem_req=0; release → mem_req=1, mem_addr=0x00, mem_we=0 on second cycle.
- Program 01 10 03 11 02 12 0F, M[10]=F0, M[11]=20 → write of 0x10 to 0x12, test_flags={C=1,Z=0}, halted=1, PC=0x07, no further requests.
- Same program, mem_ready low 3 cycles per access → identical results, addr/we/wdata stable during waits, total cycles = zero-wait count + 3×accesses.
- 0D 09 20 at 0x00 → CLR sets Z=1, JZ taken, next fetch at 0x20; 0B 09 20 → INC clears Z, next fetch at 0x03.
- SUB with AC=M=0x55 → AC=0, Z=1, C=1; SUB 0x10−0x20 → AC=0xF0, C=0; NOP at 0xFF → PC wraps to 0x00.
- Assert rst during STA MEM wait → mem_req falls immediately, no write completes, restart fetches RESET_PC.
